frame_rw_scheduler: RTL and testbench

- Sequences one edge-detection frame pass over a single shared AHB-lite master port.
- Interleaves source-pixel reads and result writes: reads start at src_base, writes start at dst_base, one 32-bit word per pixel.
- Sits between the top-level control FSM (start/done) and the AHB master interface.
- Arbitrates between the pixel-buffer read requester and the result write requester, then steps both address streams to width*length words.

---
 rtl/frame_rw_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_frame_rw_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rw_scheduler.sv
// Purpose: schedules one frame pass of interleaved pixel reads and result writes over a shared AHB-lite master port.
// Latency: 2 cycles from start to first bus_req, at least 2 cycles per transfer, 2 cycles from last write completion to done.
// Backpressure: bus_ready low holds bus_req/bus_write/bus_addr stable; rd_ready/wr_valid low keeps that requester out of arbitration.
// Optional feature macro: FRAME_RW_ABORT_EN adds an abort input that ends the pass early.
module frame_rw_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic              rd_ready,
  input  logic              wr_valid,
  input  logic              bus_ready,
`ifdef FRAME_RW_ABORT_EN
  input  logic              abort,
`endif
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              rd_grant,
  output logic              wr_grant,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               last_wr_q, last_wr_d;     // 1 = last grant was a write
  logic               abort_pend_q, abort_pend_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_write_q, bus_write_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic               rd_grant_q, rd_grant_d;
  logic               wr_grant_q, wr_grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               abort_in;
  logic               elig_rd, elig_wr;
  logic               grant_rd, grant_wr;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;

`ifdef FRAME_RW_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // Word addresses wrap modulo 2^ADDR_W.
  assign rd_addr = src_q + ADDR_W'(rd_cnt_q) * ADDR_W'(WORD_BYTES);
  assign wr_addr = dst_q + ADDR_W'(wr_cnt_q) * ADDR_W'(WORD_BYTES);

  assign elig_wr  = wr_valid && (wr_cnt_q < total_q);
  assign elig_rd  = rd_ready && (rd_cnt_q < total_q);
  // Round-robin when both want the bus: grant the type opposite to the last one.
  assign grant_wr = elig_wr && (!elig_rd || !last_wr_q);
  assign grant_rd = elig_rd && (!elig_wr || last_wr_q);

  // Next-state and next-output computation for the pass sequencer.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    total_d      = total_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    last_wr_d    = last_wr_q;
    abort_pend_d = abort_pend_q;
    bus_req_d    = bus_req_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    rd_grant_d   = 1'b0;
    wr_grant_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d        = src_base;
          dst_d        = dst_base;
          total_d      = CNT_W'(width) * CNT_W'(length);
          rd_cnt_d     = '0;
          wr_cnt_d     = '0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_ARB;
        end
      end

      S_ARB: begin
        if ((wr_cnt_q == total_q) || abort_in || abort_pend_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (grant_wr || grant_rd) begin
          bus_req_d   = 1'b1;
          bus_write_d = grant_wr;
          bus_addr_d  = grant_wr ? wr_addr : rd_addr;
          state_d     = S_XFER;
        end
      end

      S_XFER: begin
        // An abort seen mid-transfer lets the transfer finish, then ends the pass.
        if (abort_in) begin
          abort_pend_d = 1'b1;
        end
        if (bus_ready) begin
          bus_req_d = 1'b0;
          last_wr_d = bus_write_q;
          if (bus_write_q) begin
            wr_grant_d = 1'b1;
            wr_cnt_d   = wr_cnt_q + 1'b1;
          end else begin
            rd_grant_d = 1'b1;
            rd_cnt_d   = rd_cnt_q + 1'b1;
          end
          state_d = S_ARB;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight request.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      total_q      <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      last_wr_q    <= 1'b1;
      abort_pend_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      rd_grant_q   <= 1'b0;
      wr_grant_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      total_q      <= total_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      last_wr_q    <= last_wr_d;
      abort_pend_q <= abort_pend_d;
      bus_req_q    <= bus_req_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      rd_grant_q   <= rd_grant_d;
      wr_grant_q   <= wr_grant_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_write = bus_write_q;
  assign bus_addr  = bus_addr_q;
  assign rd_grant  = rd_grant_q;
  assign wr_grant  = wr_grant_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_rw_scheduler.sv
// Purpose: directed checks of frame_rw_scheduler: full pass, bus stall, starvation, zero frame, reset, abort.
// Latency: samples outputs 1 time unit after each rising edge; expected values are hand-derived cycle by cycle.
// Backpressure: bus_ready, rd_ready and wr_valid are driven directly to exercise stalls and starvation.
module tb_frame_rw_scheduler;

  logic        tb_HCLK;
  logic        HRESET;
  logic        start;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] width;
  logic [15:0] length;
  logic        rd_ready;
  logic        wr_valid;
  logic        bus_ready;
`ifdef FRAME_RW_ABORT_EN
  logic        abort;
`endif
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic        rd_grant;
  logic        wr_grant;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  frame_rw_scheduler #(
    .ADDR_W    (32),
    .DIM_W     (16),
    .WORD_BYTES(4)
  ) dut (
    .HCLK     (tb_HCLK),
    .HRESET   (HRESET),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .width    (width),
    .length   (length),
    .rd_ready (rd_ready),
    .wr_valid (wr_valid),
    .bus_ready(bus_ready),
`ifdef FRAME_RW_ABORT_EN
    .abort    (abort),
`endif
    .bus_req  (bus_req),
    .bus_write(bus_write),
    .bus_addr (bus_addr),
    .rd_grant (rd_grant),
    .wr_grant (wr_grant),
    .busy     (busy),
    .done     (done)
  );

  initial tb_HCLK = 1'b0;
  always #5 tb_HCLK = ~tb_HCLK;

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge tb_HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 2x5 pass with all requesters ready; optional 3-cycle bus stall on transfer stall_k.
  // Transfer order is RD,WR,RD,WR... because the first grant after reset is a read.
  task automatic run_pass(input string nm, input int stall_k);
    int          nrd;
    int          nwr;
    logic        ew;
    logic [31:0] ea;
    nrd = 0;
    nwr = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("%s_c1_busy_req_done", nm), {61'd0, busy, bus_req, done}, 64'b100);
    tick();
    for (int k = 0; k < 20; k++) begin
      ew = k[0];
      ea = (ew ? 32'h2000 : 32'h1000) + 32'(4 * (k / 2));
      if (k == stall_k) begin
        bus_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("%s_stall%0d", nm, s), {30'd0, bus_req, bus_write, bus_addr, rd_grant},
              {30'd0, 1'b1, ew, ea, 1'b0});
          tick();
        end
        bus_ready = 1'b1;
      end
      chk($sformatf("%s_xfer%0d", nm, k), {30'd0, bus_req, bus_write, bus_addr}, {30'd0, 1'b1, ew, ea});
      tick();
      nrd += int'(rd_grant);
      nwr += int'(wr_grant);
      chk($sformatf("%s_grant%0d", nm, k), {60'd0, rd_grant, wr_grant, bus_req, done},
          {60'd0, ~ew, ew, 2'b00});
      if (k < 19) tick();
    end
    chk($sformatf("%s_rd_count", nm), 64'(nrd), 64'd10);
    chk($sformatf("%s_wr_count", nm), 64'(nwr), 64'd10);
    tick();
    chk($sformatf("%s_done", nm), {61'd0, done, busy, bus_req}, 64'b110);
    tick();
    chk($sformatf("%s_idle", nm), {62'd0, done, busy}, 64'b00);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    HRESET    = 1'b1;
    start     = 1'b0;
    src_base  = 32'h1000;
    dst_base  = 32'h2000;
    width     = 16'd2;
    length    = 16'd5;
    rd_ready  = 1'b1;
    wr_valid  = 1'b1;
    bus_ready = 1'b1;
`ifdef FRAME_RW_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    tick();
    HRESET = 1'b0;

    // Reset state: every output low.
    chk("reset_outputs", {25'd0, bus_req, bus_write, bus_addr, rd_grant, wr_grant, busy, done}, 64'd0);

    // Full pass, no stalls.
    run_pass("full", -1);

    // Same pass with read of 0x1008 (transfer 4) stalled for 3 cycles.
    run_pass("stall", 4);

    // Starvation: writes withheld, reads run to total then the block waits in ARB.
    wr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 10; r++) begin
      tick();
      chk($sformatf("starve_rd_xfer%0d", r), {30'd0, bus_req, bus_write, bus_addr},
          {30'd0, 1'b1, 1'b0, 32'h1000 + 32'(4 * r)});
      tick();
      chk($sformatf("starve_rd_grant%0d", r), {62'd0, rd_grant, wr_grant}, 64'b10);
    end
    for (int w = 0; w < 5; w++) begin
      tick();
      chk($sformatf("starve_wait%0d", w), {61'd0, bus_req, busy, done}, 64'b010);
    end
    wr_valid = 1'b1;
    for (int w = 0; w < 10; w++) begin
      tick();
      chk($sformatf("starve_wr_xfer%0d", w), {30'd0, bus_req, bus_write, bus_addr},
          {30'd0, 1'b1, 1'b1, 32'h2000 + 32'(4 * w)});
      tick();
      chk($sformatf("starve_wr_grant%0d", w), {61'd0, rd_grant, wr_grant, done}, 64'b010);
    end
    tick();
    chk("starve_done", {61'd0, done, busy, bus_req}, 64'b110);
    tick();
    chk("starve_idle", {62'd0, done, busy}, 64'b00);

    // Zero frame: no transfers, done at start+2, busy for 2 cycles.
    width = 16'd0;
    length = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_c1", {61'd0, busy, done, bus_req}, 64'b100);
    tick();
    chk("zero_c2", {61'd0, busy, done, bus_req}, 64'b110);
    tick();
    chk("zero_c3", {61'd0, busy, done, bus_req}, 64'b000);
    width = 16'd2;
    length = 16'd5;

    // Reset during the 4th transfer (write to 0x2004), then a fresh start.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("rst_4th_xfer", {30'd0, bus_req, bus_write, bus_addr}, {30'd0, 1'b1, 1'b1, 32'h2004});
    HRESET = 1'b1;
    bus_ready = 1'b0;
    tick();
    chk("rst_outputs", {25'd0, bus_req, bus_write, bus_addr, rd_grant, wr_grant, busy, done}, 64'd0);
    HRESET = 1'b0;
    bus_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_restart_busy", {62'd0, busy, bus_req}, 64'b10);
    tick();
    chk("rst_restart_addr", {30'd0, bus_req, bus_write, bus_addr}, {30'd0, 1'b1, 1'b0, 32'h1000});
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;

`ifdef FRAME_RW_ABORT_EN
    // Abort during a stalled write: write finishes, done two cycles after completion.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_rd0", {30'd0, bus_req, bus_write, bus_addr}, {30'd0, 1'b1, 1'b0, 32'h1000});
    tick();
    bus_ready = 1'b0;
    tick();
    chk("abort_wr0", {30'd0, bus_req, bus_write, bus_addr}, {30'd0, 1'b1, 1'b1, 32'h2000});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hold", {29'd0, bus_req, bus_write, bus_addr, wr_grant}, {29'd0, 1'b1, 1'b1, 32'h2000, 1'b0});
    bus_ready = 1'b1;
    tick();
    chk("abort_wr_grant", {61'd0, wr_grant, bus_req, done}, 64'b100);
    tick();
    chk("abort_done", {61'd0, done, bus_req, busy}, 64'b101);
    tick();
    chk("abort_idle", {61'd0, done, bus_req, busy}, 64'b000);
    tick();
    chk("abort_no_req", {63'd0, bus_req}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
